// File: rtl/ni_flit_depacketizer.sv
// Receive-side NI: validates head/body/tail flit packets and reassembles the payload word.
// Optional NI_DEPKT_STATS_EN adds saturating packet/error counters.
module ni_flit_depacketizer #(
   parameter int          DATA_WIDTH    = 32,
   parameter logic [3:0]  NODE_ADDR     = 4'h0,
   parameter int          BITS_PER_FLIT = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [15:0]           flit_i,
   input  logic                  flit_valid_i,
   output logic                  flit_ready_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [3:0]            src_o,
   output logic [2:0]            mode_o,
   output logic [1:0]            flag_o,
   output logic                  data_valid_o,
   input  logic                  data_ready_i,
   output logic                  err_o,
   output logic [1:0]            err_code_o
`ifdef NI_DEPKT_STATS_EN
   ,
   output logic [15:0]           pkt_count_o,
   output logic [15:0]           err_count_o
`endif
);

   localparam int NB    = (DATA_WIDTH + BITS_PER_FLIT - 1) / BITS_PER_FLIT;
   localparam int TOTAL = NB + 2;
   localparam int BW    = NB * BITS_PER_FLIT;
   localparam int CW    = $clog2(NB + 8);

   typedef enum logic [2:0] {S_IDLE, S_BODY, S_TAIL, S_OUT, S_DROP} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [BW-1:0]   buf_q, buf_d;
   logic [3:0]      src_q, src_d;
   logic [2:0]      mode_q, mode_d;
   logic [1:0]      flag_q, flag_d;
   logic            vld_q, vld_d;
   logic            rdy_q, rdy_d;
   logic            err_q, err_d;
   logic [1:0]      code_q, code_d;
   logic            acc;
   logic [2:0]      nof;

   assign acc = flit_valid_i & rdy_q;
   assign nof = flit_i[15:13];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      src_d   = src_q;
      mode_d  = mode_q;
      flag_d  = flag_q;
      vld_d   = vld_q;
      err_d   = 1'b0;
      code_d  = code_q;
      case (state_q)
         S_IDLE: if (acc) begin
            if (flit_i[7:4] != NODE_ADDR || nof != 3'(TOTAL)) begin
               err_d   = 1'b1;
               code_d  = (flit_i[7:4] != NODE_ADDR) ? 2'b01 : 2'b10;
               cnt_d   = (nof > 3'd1) ? CW'(nof - 3'd1) : '0;
               state_d = S_DROP;
            end else begin
               src_d   = flit_i[3:0];
               mode_d  = flit_i[10:8];
               flag_d  = flit_i[12:11];
               cnt_d   = '0;
               state_d = S_BODY;
            end
         end
         S_BODY: if (acc) begin
            if (flit_i[0]) begin
               err_d   = 1'b1;
               code_d  = 2'b11;
               state_d = S_IDLE;
            end else begin
               // Chunks shift in from the top so body 0 ends up in the low bits.
               buf_d = {flit_i[BITS_PER_FLIT:1], buf_q[BW-1:BITS_PER_FLIT]};
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(NB - 1)) state_d = S_TAIL;
            end
         end
         S_TAIL: if (acc) begin
            if (flit_i[0]) begin
               vld_d   = 1'b1;
               state_d = S_OUT;
            end else begin
               err_d   = 1'b1;
               code_d  = 2'b11;
               state_d = S_IDLE;
            end
         end
         S_OUT: if (data_ready_i) begin
            vld_d   = 1'b0;
            state_d = S_IDLE;
         end
         S_DROP: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else if (acc) begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CW'(1)) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A drop with nothing left to consume must not swallow the next head.
      rdy_d = (state_d != S_OUT) && !(state_d == S_DROP && cnt_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         buf_q   <= '0;
         src_q   <= '0;
         mode_q  <= '0;
         flag_q  <= '0;
         vld_q   <= 1'b0;
         rdy_q   <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         src_q   <= src_d;
         mode_q  <= mode_d;
         flag_q  <= flag_d;
         vld_q   <= vld_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   assign flit_ready_o = rdy_q;
   assign data_o       = buf_q[DATA_WIDTH-1:0];
   assign src_o        = src_q;
   assign mode_o       = mode_q;
   assign flag_o       = flag_q;
   assign data_valid_o = vld_q;
   assign err_o        = err_q;
   assign err_code_o   = code_q;

`ifdef NI_DEPKT_STATS_EN
   logic [15:0] pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      err_cnt_d = err_cnt_q;
      if (vld_q && data_ready_i && pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
      if (err_q && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign pkt_count_o = pkt_cnt_q;
   assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_ni_flit_depacketizer.sv
// Scoreboard bench for ni_flit_depacketizer: directed cases then randomized packet mix.
module tb_ni_flit_depacketizer;
   localparam logic [3:0] NODE = 4'h2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] flit_i = '0;
   logic        flit_valid_i = 1'b0;
   logic        flit_ready_o;
   logic [31:0] data_o;
   logic [3:0]  src_o;
   logic [2:0]  mode_o;
   logic [1:0]  flag_o;
   logic        data_valid_o;
   logic        data_ready_i = 1'b1;
   logic        err_o;
   logic [1:0]  err_code_o;
`ifdef NI_DEPKT_STATS_EN
   logic [15:0] pkt_count_o, err_count_o;
`endif

   ni_flit_depacketizer #(.DATA_WIDTH(32), .NODE_ADDR(NODE), .BITS_PER_FLIT(14)) dut (
      .clk(clk), .rst_n(rst_n), .flit_i(flit_i), .flit_valid_i(flit_valid_i),
      .flit_ready_o(flit_ready_o), .data_o(data_o), .src_o(src_o), .mode_o(mode_o),
      .flag_o(flag_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
      .err_o(err_o), .err_code_o(err_code_o)
`ifdef NI_DEPKT_STATS_EN
      , .pkt_count_o(pkt_count_o), .err_count_o(err_count_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  s;
      logic [2:0]  m;
      logic [1:0]  f;
   } rec_t;

   rec_t       exp_q[$];
   logic [1:0] experr_q[$];
   int  n_tests = 0, n_fail = 0;
   int  exp_pkts = 0, exp_errs = 0;
   bit  gap_en = 0, rdy_rand = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got %0h want %0h", nm, got, want);
      end
   endtask

   // Monitor: pops the scoreboard on every output handshake and error pulse.
   always @(negedge clk) if (rst_n) begin
      if (data_valid_o) chk("no_accept_in_out", flit_ready_o, 1'b0);
      if (data_valid_o && data_ready_i) begin
         if (exp_q.size() == 0) chk("unexpected_valid", 1'b1, 1'b0);
         else begin
            rec_t e;
            e = exp_q.pop_front();
            chk("data", data_o, e.d);
            chk("meta", {src_o, mode_o, flag_o}, {e.s, e.m, e.f});
         end
      end
      if (err_o) begin
         if (experr_q.size() == 0) chk("unexpected_err", 1'b1, 1'b0);
         else chk("err_code", err_code_o, experr_q.pop_front());
      end
   end

   initial forever begin
      @(posedge clk); #1;
      if (rdy_rand) data_ready_i = ($urandom_range(0, 2) != 0);
   end

   // Call at posedge+1; returns at posedge+1 after the flit was taken.
   task automatic send(input logic [15:0] f);
      int n = 0;
      bit acc = 0;
      while (gap_en && $urandom_range(0, 3) == 0) begin
         flit_valid_i = 1'b0;
         @(posedge clk); #1;
      end
      flit_valid_i = 1'b1;
      flit_i = f;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = flit_ready_o;
         @(posedge clk); #1;
         n++;
      end
      flit_valid_i = 1'b0;
      if (!acc) chk("flit_accept_timeout", 1'b0, 1'b1);
   endtask

   task automatic push_pkt(input logic [31:0] d, input logic [3:0] s, input logic [2:0] m,
                           input logic [1:0] f);
      exp_q.push_back('{d, s, m, f});
      exp_pkts++;
   endtask

   task automatic push_err(input logic [1:0] c);
      experr_q.push_back(c);
      exp_errs++;
   endtask

   // r holds 3x14 payload bits; only r[31:0] may reach data_o.
   task automatic good_pkt(input logic [41:0] r, input logic [3:0] s, input logic [2:0] m,
                           input logic [1:0] f);
      push_pkt(r[31:0], s, m, f);
      send({3'd5, f, m, NODE, s});
      for (int k = 0; k < 3; k++) send({1'($urandom), r[k*14 +: 14], 1'b0});
      send({15'($urandom), 1'b1});
   endtask

   task automatic pkt_a();
      logic [15:0] fl[5];
      fl = '{16'hA127, 16'h7DDE, 16'h756C, 16'h001A, 16'h0001};
      push_pkt(32'hDEADBEEF, 4'h7, 3'd1, 2'd0);
      for (int k = 0; k < 5; k++) send(fl[k]);
   endtask

   initial begin
      logic [2:0] nof;
      logic [3:0] dst;
      int kind, nfill, j;
      bit done;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", flit_ready_o, 1'b0);
      chk("rst_outs", {data_o, src_o, mode_o, flag_o, data_valid_o, err_o, err_code_o}, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("ready_after_rst", flit_ready_o, 1'b1);
      @(posedge clk); #1;

      // Good packet and output latency
      pkt_a();
      @(negedge clk);
      chk("valid_lat", data_valid_o, 1'b1);
      chk("no_err_good", err_o, 1'b0);
      @(posedge clk); #1;

      // Backpressure with next head offered
      data_ready_i = 1'b0;
      pkt_a();
      push_pkt(32'hDEADBEEF, 4'h7, 3'd1, 2'd0);
      flit_valid_i = 1'b1;
      flit_i = 16'hA127;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("bp_ready", flit_ready_o, 1'b0);
         chk("bp_hold", {data_valid_o, data_o, src_o}, {1'b1, 32'hDEADBEEF, 4'h7});
         @(posedge clk); #1;
      end
      data_ready_i = 1'b1;
      @(negedge clk);
      chk("bp_ready_hs", flit_ready_o, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ready_after_hs", flit_ready_o, 1'b1);
      @(posedge clk); #1;
      flit_valid_i = 1'b0;
      send(16'h7DDE); send(16'h756C); send(16'h001A); send(16'h0001);

      // Destination mismatch
      push_err(2'b01);
      send(16'hA137);
      @(negedge clk);
      chk("dest_err_pulse", {err_o, err_code_o}, {1'b1, 2'b01});
      @(posedge clk); #1;
      repeat (4) send(16'($urandom));
      pkt_a();

      // Identifier error in body, then good packet on the next flit
      send(16'hA127); send(16'h7DDE);
      push_err(2'b11);
      send(16'h756D);
      pkt_a();
      @(negedge clk);
      chk("code_held", err_code_o, 2'b11);
      @(posedge clk); #1;

      // Reset mid-packet
      repeat (3) @(posedge clk);
      #1;
      send(16'hA127); send(16'h7DDE);
      rst_n = 1'b0;
      #2;
      chk("midrst_outs", {flit_ready_o, data_o, src_o, mode_o, flag_o, data_valid_o, err_o,
                          err_code_o}, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
`ifdef NI_DEPKT_STATS_EN
      exp_pkts = 0;
      exp_errs = 0;
`endif
      @(posedge clk); #1;
      pkt_a();

      // Randomized mix
      gap_en = 1;
      rdy_rand = 1;
      for (int it = 0; it < 80; it++) begin
         kind = $urandom_range(0, 4);
         case (kind)
            0: good_pkt({10'($urandom), 32'($urandom)}, 4'($urandom), 3'($urandom), 2'($urandom));
            1, 2: begin
               dst = (kind == 1) ? 4'($urandom) : NODE;
               if (kind == 1 && dst == NODE) dst = dst ^ 4'h1;
               nof = 3'($urandom);
               if (kind == 2 && nof == 3'd5) nof = 3'd6;
               push_err(kind == 1 ? 2'b01 : 2'b10);
               send({nof, 2'($urandom), 3'($urandom), dst, 4'($urandom)});
               nfill = (nof > 1) ? int'(nof) - 1 : 0;
               repeat (nfill) send(16'($urandom));
            end
            3: begin
               j = $urandom_range(0, 2);
               send({3'd5, 2'($urandom), 3'($urandom), NODE, 4'($urandom)});
               repeat (j) send({15'($urandom), 1'b0});
               push_err(2'b11);
               send({15'($urandom), 1'b1});
            end
            default: begin
               send({3'd5, 2'($urandom), 3'($urandom), NODE, 4'($urandom)});
               repeat (3) send({15'($urandom), 1'b0});
               push_err(2'b11);
               send({15'($urandom), 1'b0});
            end
         endcase
      end
      gap_en = 0;
      rdy_rand = 0;
      data_ready_i = 1'b1;

      done = 0;
      for (int c = 0; c < 300 && !done; c++) begin
         @(posedge clk); #1;
         done = (exp_q.size() == 0 && experr_q.size() == 0);
      end
      chk("drain_pkts_left", exp_q.size(), 0);
      chk("drain_errs_left", experr_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
`ifdef NI_DEPKT_STATS_EN
      chk("pkt_count", pkt_count_o, exp_pkts);
      chk("err_count", err_count_o, exp_errs);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
